// File: rtl/mux_rr_read_arbiter.sv
// mux_rr_read_arbiter: round-robin share of one 32:1 register read mux; MUX_ARB_LOCK_EN adds req_lock
module mux_rr_read_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [5*NUM_REQ-1:0] req_idx,
`ifdef MUX_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]   req_lock,
`endif
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [4:0]           sel_i_32,
    input  logic [31:0]          mux_data,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [31:0]          rsp_data,
    input  logic                 rsp_ready
);
    logic            s1_valid, s1_adv, s2_adv, any;
    logic [ID_W-1:0] s1_id, rr_ptr, win, k;
    assign s2_adv    = !rsp_valid || rsp_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign any       = |req_valid;
    assign req_ready = (s1_adv && any) ? NUM_REQ'(1) << win : '0;
    always_comb begin
        win = rr_ptr;
        k   = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            k = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            win = req_valid[k] ? k : win;
        end
`ifdef MUX_ARB_LOCK_EN
        win = (req_lock[rr_ptr] && req_valid[rr_ptr]) ? rr_ptr : win;
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_id     <= '0;
            sel_i_32  <= '0;
            rr_ptr    <= ID_W'(NUM_REQ - 1);
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= any;
                if (any) begin
                    sel_i_32 <= req_idx[5*win +: 5];
                    s1_id    <= win;
                    rr_ptr   <= win;
                end
            end
            if (s2_adv) begin
                rsp_valid <= s1_valid;
                if (s1_valid) begin
                    rsp_data <= mux_data;
                    rsp_id   <= s1_id;
                end
            end
        end
    end
endmodule

// File: tb/tb_mux_rr_read_arbiter.sv
// tb_mux_rr_read_arbiter: directed checks of grant order, pipeline latency, stall, reset flush and lock
module tb_mux_rr_read_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [19:0] req_idx = '0;
    logic [3:0]  req_lock = '0;
    logic [3:0]  req_ready;
    logic [4:0]  sel_i_32;
    logic [31:0] mux_data;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_ready = 1'b1;
    int tests = 0;
    int fails = 0;

    mux_rr_read_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_idx(req_idx),
`ifdef MUX_ARB_LOCK_EN
        .req_lock(req_lock),
`endif
        .req_ready(req_ready), .sel_i_32(sel_i_32), .mux_data(mux_data),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rf(input logic [4:0] r);
        return {16'hC0DE, 3'd0, r, ~r, 3'd0};
    endfunction
    assign mux_data = rf(sel_i_32);

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b1; req_lock = '0;
        req_idx = {5'd19, 5'd18, 5'd17, 5'd16};
        cyc(); cyc();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (req_ready !== 4'b0) begin fails++; $display("FAIL reset req_ready got %b want 0000", req_ready); end
        tests++; if (sel_i_32 !== 5'd0) begin fails++; $display("FAIL reset sel_i_32 got %0d want 0", sel_i_32); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset rsp_valid got %b want 0", rsp_valid); end
        tests++; if (rsp_id !== 2'd0) begin fails++; $display("FAIL reset rsp_id got %0d want 0", rsp_id); end
        tests++; if (rsp_data !== 32'd0) begin fails++; $display("FAIL reset rsp_data got %h want 0", rsp_data); end
    endtask

    task automatic test_single();
        do_reset();
        req_idx[4:0] = 5'd7; req_valid = 4'b0001;
        #1;
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL single grant got %b want 0001", req_ready); end
        cyc();
        req_valid = '0;
        tests++; if (sel_i_32 !== 5'd7) begin fails++; $display("FAIL single sel got %0d want 7", sel_i_32); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL single early rsp_valid got %b want 0", rsp_valid); end
        cyc();
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL single rsp_valid got %b want 1", rsp_valid); end
        tests++; if (rsp_id !== 2'd0) begin fails++; $display("FAIL single rsp_id got %0d want 0", rsp_id); end
        tests++; if (rsp_data !== rf(5'd7)) begin fails++; $display("FAIL single rsp_data got %h want %h", rsp_data, rf(5'd7)); end
        cyc();
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL single drain rsp_valid got %b want 0", rsp_valid); end
    endtask

    task automatic test_all_valid();
        do_reset();
        req_valid = 4'b1111;
        for (int n = 0; n < 6; n++) begin
            #1;
            tests++; if (req_ready !== 4'(1 << (n % 4))) begin fails++; $display("FAIL all grant n=%0d got %b want %b", n, req_ready, 4'(1 << (n % 4))); end
            cyc();
            tests++; if (sel_i_32 !== 5'(16 + n % 4)) begin fails++; $display("FAIL all sel n=%0d got %0d want %0d", n, sel_i_32, 16 + n % 4); end
            if (n >= 1) begin
                tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'((n - 1) % 4) || rsp_data !== rf(5'(16 + (n - 1) % 4)))
                    begin fails++; $display("FAIL all rsp n=%0d got v=%b id=%0d d=%h want v=1 id=%0d", n, rsp_valid, rsp_id, rsp_data, (n - 1) % 4); end
            end
        end
        req_valid = '0;
        cyc();
        tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin fails++; $display("FAIL all last rsp got v=%b id=%0d want v=1 id=1", rsp_valid, rsp_id); end
        cyc();
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL all drain rsp_valid got %b want 0", rsp_valid); end
    endtask

    task automatic test_stall();
        do_reset();
        req_valid = 4'b1111;
        cyc(); cyc();
        rsp_ready = 1'b0;
        #1;
        tests++; if (req_ready !== 4'b0) begin fails++; $display("FAIL stall grant got %b want 0000", req_ready); end
        for (int n = 0; n < 3; n++) begin
            cyc();
            tests++; if (req_ready !== 4'b0) begin fails++; $display("FAIL stall grant c%0d got %b want 0000", n, req_ready); end
            tests++; if (sel_i_32 !== 5'd17) begin fails++; $display("FAIL stall sel c%0d got %0d want 17", n, sel_i_32); end
            tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== rf(5'd16)) begin fails++; $display("FAIL stall hold c%0d got v=%b id=%0d d=%h want v=1 id=0", n, rsp_valid, rsp_id, rsp_data); end
        end
        rsp_ready = 1'b1;
        #1;
        tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL stall release grant got %b want 0100", req_ready); end
        cyc();
        req_valid = '0;
        tests++; if (rsp_id !== 2'd1 || rsp_data !== rf(5'd17) || sel_i_32 !== 5'd18) begin fails++; $display("FAIL stall release1 got id=%0d sel=%0d want id=1 sel=18", rsp_id, sel_i_32); end
        cyc();
        tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin fails++; $display("FAIL stall release2 got v=%b id=%0d want v=1 id=2", rsp_valid, rsp_id); end
        cyc();
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL stall drain rsp_valid got %b want 0", rsp_valid); end
    endtask

    task automatic test_sparse();
        do_reset();
        req_valid = 4'b1010;
        for (int n = 0; n < 4; n++) begin
            #1;
            tests++; if (req_ready !== 4'(1 << (n % 2 == 0 ? 1 : 3))) begin fails++; $display("FAIL sparse grant n=%0d got %b want %0d", n, req_ready, n % 2 == 0 ? 1 : 3); end
            cyc();
            if (n >= 1) begin
                tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(n % 2 == 1 ? 1 : 3)) begin fails++; $display("FAIL sparse rsp n=%0d got v=%b id=%0d", n, rsp_valid, rsp_id); end
            end
        end
        req_valid = '0;
        cyc(); cyc();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_idx[4:0] = 5'd7; req_valid = 4'b0001;
        cyc();
        rst = 1'b1; req_valid = '0;
        cyc();
        tests++; if (rsp_valid !== 1'b0 || sel_i_32 !== 5'd0 || rsp_id !== 2'd0) begin fails++; $display("FAIL rstmid state got v=%b sel=%0d id=%0d want 0 0 0", rsp_valid, sel_i_32, rsp_id); end
        rst = 1'b0;
        cyc();
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rstmid flushed rsp_valid got %b want 0", rsp_valid); end
        req_valid = 4'b1111;
        #1;
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL rstmid first grant got %b want 0001", req_ready); end
        req_valid = '0;
        cyc();
    endtask

`ifdef MUX_ARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        req_valid = 4'b1111;
        cyc(); cyc();
        req_lock = 4'b0100;
        for (int n = 0; n < 3; n++) begin
            #1;
            tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL lock grant n=%0d got %b want 0100", n, req_ready); end
            cyc();
        end
        req_lock = '0;
        #1;
        tests++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL lock release grant got %b want 1000", req_ready); end
        req_valid = '0;
        cyc(); cyc();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_all_valid();
        test_stall();
        test_sparse();
        test_reset_mid();
`ifdef MUX_ARB_LOCK_EN
        test_lock();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
